alu_arbiter: RTL and testbench

- Shares the single combinational 8-bit ALU between two requesters, r0 and r1.
- Each requester presents an operation with a req level. The block arbitrates round-robin and latches the winner's operands, opcode, select and carry-in.
- It drives the ALU from registers for one cycle, captures ALU_Out/CarryOut/OverflowFlag, and returns them to the winner with a one-cycle done pulse.
- Sits between the issuing control units and the ALU instance.

---
 rtl/alu_arbiter.sv | 152 +++++++++++++++
 tb/tb_alu_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 8-bit ALU between two requesters.
// Optional macro ALU_ARB_STICKY_EN adds per-requester sticky overflow/carry flags.
module alu_arbiter #(
  parameter int DATA_W = 8,
  parameter int OPC_W  = 5,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic [SEL_W-1:0]  r0_sel,
  input  logic [OPC_W-1:0]  r0_opcode,
  input  logic              r0_cin,
  output logic              r0_gnt,
  output logic              r0_done,
  input  logic              r1_req,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  input  logic [SEL_W-1:0]  r1_sel,
  input  logic [OPC_W-1:0]  r1_opcode,
  input  logic              r1_cin,
  output logic              r1_gnt,
  output logic              r1_done,
  output logic [DATA_W-1:0] res_data,
  output logic              res_cout,
  output logic              res_ovf,
  output logic              busy,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  output logic [OPC_W-1:0]  alu_opcode,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_cout,
  input  logic              alu_ovf,
`ifdef ALU_ARB_STICKY_EN
  input  logic              sticky_clr,
  output logic              r0_ovf_sticky,
  output logic              r1_ovf_sticky,
  output logic              r0_cout_sticky,
  output logic              r1_cout_sticky,
`endif
  output logic [1:0]        state_dbg
);

  // Handshake: a requester holds req and operands stable until its gnt pulse;
  // the operation is latched on that edge, and done pulses one cycle after gnt
  // with res_* valid. A req still high once the arbiter is back in IDLE is a
  // new request.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  logic   ptr;    // requester favoured on a tie (0 = r0, 1 = r1)
  logic   owner;  // requester whose operation is in flight
  logic   win;

  assign state_dbg = state;

  always_comb begin
    win = r1_req;
    if (r0_req && r1_req) win = ptr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      owner      <= 1'b0;
      r0_gnt     <= 1'b0;
      r1_gnt     <= 1'b0;
      r0_done    <= 1'b0;
      r1_done    <= 1'b0;
      res_data   <= '0;
      res_cout   <= 1'b0;
      res_ovf    <= 1'b0;
      busy       <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      alu_opcode <= '0;
      alu_cin    <= 1'b0;
    end else begin
      r0_gnt <= 1'b0;
      r1_gnt <= 1'b0;
      case (state)
        IDLE: begin
          if (r0_req || r1_req) begin
            owner      <= win;
            ptr        <= ~win;
            r0_gnt     <= ~win;
            r1_gnt     <= win;
            alu_a      <= win ? r1_a      : r0_a;
            alu_b      <= win ? r1_b      : r0_b;
            alu_sel    <= win ? r1_sel    : r0_sel;
            alu_opcode <= win ? r1_opcode : r0_opcode;
            alu_cin    <= win ? r1_cin    : r0_cin;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          res_data <= alu_out;
          res_cout <= alu_cout;
          res_ovf  <= alu_ovf;
          r0_done  <= ~owner;
          r1_done  <= owner;
          state    <= DONE;
        end
        DONE: begin
          r0_done <= 1'b0;
          r1_done <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STICKY_EN
  // Clear is written first so a same-edge set overrides it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_ovf_sticky  <= 1'b0;
      r1_ovf_sticky  <= 1'b0;
      r0_cout_sticky <= 1'b0;
      r1_cout_sticky <= 1'b0;
    end else begin
      if (sticky_clr) begin
        r0_ovf_sticky  <= 1'b0;
        r1_ovf_sticky  <= 1'b0;
        r0_cout_sticky <= 1'b0;
        r1_cout_sticky <= 1'b0;
      end
      if (state == EXEC) begin
        if (alu_ovf  && !owner) r0_ovf_sticky  <= 1'b1;
        if (alu_ovf  &&  owner) r1_ovf_sticky  <= 1'b1;
        if (alu_cout && !owner) r0_cout_sticky <= 1'b1;
        if (alu_cout &&  owner) r1_cout_sticky <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: adder ALU stub, cycle-level transaction
// model, per-cycle compare, directed literal checks and randomized traffic.
module tb_alu_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       r0_req = 0, r1_req = 0;
  logic [7:0] r0_a = 0, r0_b = 0, r1_a = 0, r1_b = 0;
  logic [1:0] r0_sel = 0, r1_sel = 0;
  logic [4:0] r0_opcode = 0, r1_opcode = 0;
  logic       r0_cin = 0, r1_cin = 0;
  logic       sticky_clr = 0;
  logic       r0_gnt, r1_gnt, r0_done, r1_done;
  logic [7:0] res_data, alu_a, alu_b, alu_out;
  logic       res_cout, res_ovf, busy, alu_cin, alu_cout, alu_ovf;
  logic [1:0] alu_sel, state_dbg;
  logic [4:0] alu_opcode;
`ifdef ALU_ARB_STICKY_EN
  logic r0_ovf_sticky, r1_ovf_sticky, r0_cout_sticky, r1_cout_sticky;
`endif

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_a(r0_a), .r0_b(r0_b), .r0_sel(r0_sel),
    .r0_opcode(r0_opcode), .r0_cin(r0_cin), .r0_gnt(r0_gnt), .r0_done(r0_done),
    .r1_req(r1_req), .r1_a(r1_a), .r1_b(r1_b), .r1_sel(r1_sel),
    .r1_opcode(r1_opcode), .r1_cin(r1_cin), .r1_gnt(r1_gnt), .r1_done(r1_done),
    .res_data(res_data), .res_cout(res_cout), .res_ovf(res_ovf), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_opcode(alu_opcode),
    .alu_cin(alu_cin), .alu_out(alu_out), .alu_cout(alu_cout), .alu_ovf(alu_ovf),
`ifdef ALU_ARB_STICKY_EN
    .sticky_clr(sticky_clr),
    .r0_ovf_sticky(r0_ovf_sticky), .r1_ovf_sticky(r1_ovf_sticky),
    .r0_cout_sticky(r0_cout_sticky), .r1_cout_sticky(r1_cout_sticky),
`endif
    .state_dbg(state_dbg)
  );

  // ALU stub: 9-bit add with signed overflow
  logic [8:0] stub_sum;
  assign stub_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
  assign {alu_cout, alu_out} = stub_sum;
  assign alu_ovf = (alu_a[7] == alu_b[7]) && (stub_sum[7] != alu_a[7]);

  // ---------------- scoreboard counters ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Time-based: an accepted op at cycle k grants in k, completes in k+1,
  // and the arbiter can accept again at cycle k+3.
  int         m_cyc, m_next_free, m_acc;
  bit         m_ptr, m_id;
  logic [7:0] m_a, m_b, m_res, p_res;
  logic [1:0] m_sel;
  logic [4:0] m_opc;
  logic       m_cin, m_cout, m_ovf, p_cout, p_ovf;
  bit         m_ovf_st[2], m_cout_st[2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc = 0; m_next_free = 0; m_acc = -10; m_ptr = 0; m_id = 0;
      m_a = 0; m_b = 0; m_sel = 0; m_opc = 0; m_cin = 0;
      m_res = 0; m_cout = 0; m_ovf = 0;
      for (int i = 0; i < 2; i++) begin m_ovf_st[i] = 0; m_cout_st[i] = 0; end
    end else begin
      m_cyc++;
      if (sticky_clr)
        for (int i = 0; i < 2; i++) begin m_ovf_st[i] = 0; m_cout_st[i] = 0; end
      if (m_cyc == m_acc + 1) begin
        m_res = p_res; m_cout = p_cout; m_ovf = p_ovf;
        if (p_ovf)  m_ovf_st[m_id]  = 1;
        if (p_cout) m_cout_st[m_id] = 1;
      end
      if (m_cyc >= m_next_free && (r0_req || r1_req)) begin
        int u, s;
        m_id  = (r0_req && r1_req) ? m_ptr : r1_req;
        m_ptr = !m_id;
        m_a   = m_id ? r1_a : r0_a;
        m_b   = m_id ? r1_b : r0_b;
        m_sel = m_id ? r1_sel : r0_sel;
        m_opc = m_id ? r1_opcode : r0_opcode;
        m_cin = m_id ? r1_cin : r0_cin;
        u = int'(m_a) + int'(m_b) + int'(m_cin);
        s = int'($signed(m_a)) + int'($signed(m_b)) + int'(m_cin);
        p_res  = u[7:0];
        p_cout = (u > 255);
        p_ovf  = (s > 127) || (s < -128);
        m_acc = m_cyc;
        m_next_free = m_cyc + 3;
      end
    end
  end

  // compare process: every cycle, mid-period
  always @(negedge clk) begin
    chk("r0_gnt",  r0_gnt,  (m_cyc == m_acc) && !m_id);
    chk("r1_gnt",  r1_gnt,  (m_cyc == m_acc) &&  m_id);
    chk("r0_done", r0_done, (m_cyc == m_acc + 1) && !m_id);
    chk("r1_done", r1_done, (m_cyc == m_acc + 1) &&  m_id);
    chk("busy",    busy,    (m_cyc == m_acc) || (m_cyc == m_acc + 1));
    chk("res_data", res_data, m_res);
    chk("res_cout", res_cout, m_cout);
    chk("res_ovf",  res_ovf,  m_ovf);
    chk("alu_a",   alu_a,   m_a);
    chk("alu_b",   alu_b,   m_b);
    chk("alu_sel", alu_sel, m_sel);
    chk("alu_opcode", alu_opcode, m_opc);
    chk("alu_cin", alu_cin, m_cin);
`ifdef ALU_ARB_STICKY_EN
    chk("r0_ovf_sticky",  r0_ovf_sticky,  m_ovf_st[0]);
    chk("r1_ovf_sticky",  r1_ovf_sticky,  m_ovf_st[1]);
    chk("r0_cout_sticky", r0_cout_sticky, m_cout_st[0]);
    chk("r1_cout_sticky", r1_cout_sticky, m_cout_st[1]);
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input bit id, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] sel, input logic [4:0] opc, input logic cin);
    if (id) begin r1_a = a; r1_b = b; r1_sel = sel; r1_opcode = opc; r1_cin = cin; end
    else    begin r0_a = a; r0_b = b; r0_sel = sel; r0_opcode = opc; r0_cin = cin; end
  endtask

  task automatic wait_gnt(input bit id, input int max_cyc, output bit ok);
    ok = 0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      tick();
      if ((!id && r0_gnt) || (id && r1_gnt)) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_gnt r%0d: no grant within %0d cycles", id, max_cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  // ---------------- stimulus ----------------
  int gnt_cyc[$];
  bit gnt_id[$];

  initial begin
    bit ok;
    tick(); tick();
    chk("reset_busy", busy, 0);
    chk("reset_res",  res_data, 0);
    chk("reset_alu_a", alu_a, 0);
    rst = 0;

    // single r0 op; operand change after grant must not leak into the result
    set_op(0, 8'hE7, 8'h98, 2'd1, 5'd3, 1'b1); r0_req = 1;
    wait_gnt(0, 5, ok);
    r0_req = 0;
    tick();
    r0_a = 8'h00;
    chk("lit_r0_done", r0_done, 1);
    chk("lit_r0_res",  res_data, 8'h80);
    chk("lit_r0_cout", res_cout, 1);
    chk("lit_r0_ovf",  res_ovf, 0);
    tick();
    chk("lit_r0_done_drop", r0_done, 0);

    // both held from reset: alternating grants, three cycles apart
    r0_req = 0; r1_req = 0; rst = 1; tick(); tick();
    set_op(0, 8'h11, 8'h22, 2'd0, 5'd1, 1'b0);
    set_op(1, 8'hF0, 8'h20, 2'd2, 5'd7, 1'b1);
    r0_req = 1; r1_req = 1; rst = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (r0_gnt) begin gnt_cyc.push_back(i); gnt_id.push_back(0); end
      if (r1_gnt) begin gnt_cyc.push_back(i); gnt_id.push_back(1); end
    end
    r0_req = 0; r1_req = 0;
    chk("lit_rr_count", gnt_id.size(), 4);
    if (gnt_id.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("lit_rr_order", gnt_id[i], i % 2);
      for (int i = 1; i < 4; i++) chk("lit_rr_gap", gnt_cyc[i] - gnt_cyc[i-1], 3);
    end
    repeat (4) tick();

    // r1 alone, signed overflow
    set_op(1, 8'h7F, 8'h01, 2'd3, 5'd9, 1'b0); r1_req = 1;
    wait_gnt(1, 5, ok);
    r1_req = 0;
    tick();
    chk("lit_r1_done", r1_done, 1);
    chk("lit_r1_r0done", r0_done, 0);
    chk("lit_r1_res",  res_data, 8'h80);
    chk("lit_r1_ovf",  res_ovf, 1);
    chk("lit_r1_cout", res_cout, 0);
    tick(); tick();

    // reset during EXEC aborts at once, then r0 wins the tie
    set_op(1, 8'h05, 8'h06, 2'd1, 5'd2, 1'b0); r1_req = 1;
    wait_gnt(1, 5, ok);
    r1_req = 0; rst = 1; #1;
    chk("lit_abort_busy", busy, 0);
    chk("lit_abort_gnt",  r1_gnt, 0);
    chk("lit_abort_alu_a", alu_a, 0);
    chk("lit_abort_res",  res_data, 0);
    tick(); tick();
    set_op(0, 8'h01, 8'h02, 2'd0, 5'd4, 1'b0);
    r0_req = 1; r1_req = 1; rst = 0;
    tick();
    chk("lit_post_rst_r0", r0_gnt, 1);
    chk("lit_post_rst_r1", r1_gnt, 0);
    r0_req = 0; r1_req = 0;
    repeat (3) tick();

`ifdef ALU_ARB_STICKY_EN
    set_op(1, 8'h7F, 8'h01, 2'd0, 5'd0, 1'b0); r1_req = 1;
    wait_gnt(1, 5, ok);
    r1_req = 0; tick();
    chk("lit_st_r1_ovf", r1_ovf_sticky, 1);
    chk("lit_st_r0_ovf", r0_ovf_sticky, 0);
    tick(); tick();
    r1_req = 1;
    wait_gnt(1, 5, ok);
    r1_req = 0; sticky_clr = 1;
    tick();
    sticky_clr = 0;
    chk("lit_st_set_wins", r1_ovf_sticky, 1);
    tick(); sticky_clr = 1; tick(); sticky_clr = 0;
    chk("lit_st_cleared", r1_ovf_sticky, 0);
    tick();
`endif

    // randomized traffic obeying the hold-until-grant rule
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int id = 0; id < 2; id++) begin
        logic req_now, gnt_now;
        logic [7:0] ra, rb;
        req_now = id ? r1_req : r0_req;
        gnt_now = id ? r1_gnt : r0_gnt;
        ra = ($urandom_range(0, 3) == 0) ? 8'h7F : 8'($urandom);
        rb = 8'($urandom);
        if ((req_now && gnt_now) || !req_now) begin
          if ($urandom_range(0, 1) == 1)
            set_op(id[0], ra, rb, 2'($urandom), 5'($urandom), 1'($urandom));
          req_now = ($urandom_range(0, 1) == 1);
        end else if ($urandom_range(0, 15) == 0) begin
          req_now = 0;
        end
        if (id == 1) r1_req = req_now; else r0_req = req_now;
      end
`ifdef ALU_ARB_STICKY_EN
      sticky_clr = ($urandom_range(0, 7) == 0);
`endif
      if (c == 1500) begin rst = 1; #2; rst = 0; end
    end
    r0_req = 0; r1_req = 0; sticky_clr = 0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
